// File: rtl/lsu_dmem_master.sv
// Load/store initiator between the execute stage and data memory: validates one
// request at a time, drives the dmem strobes for a single ACCESS cycle, returns load data.
module lsu_dmem_master #(
    parameter logic [31:0] DM_BASE  = 32'h10010000,
    parameter int unsigned DM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    output logic [31:0] rdata,
    output logic        dm_ena,
    output logic        dm_rena,
    output logic        dm_wena,
    output logic [3:0]  dm_wflag,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [2:0] OpLb  = 3'b000;
    localparam logic [2:0] OpLbu = 3'b001;
    localparam logic [2:0] OpLh  = 3'b010;
    localparam logic [2:0] OpLhu = 3'b011;
    localparam logic [2:0] OpLw  = 3'b100;
    localparam logic [2:0] OpSb  = 3'b101;
    localparam logic [2:0] OpSh  = 3'b110;
    localparam logic [2:0] OpSw  = 3'b111;

    // Highest address at which a full word still fits inside the window.
    localparam logic [31:0] DmLast = DM_BASE + 32'(DM_BYTES) - 32'd4;

    typedef enum logic {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_misaligned;
    logic        req_out_of_range;
    logic        is_store_q;
    logic [31:0] byte_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;

    always_comb begin
        req_misaligned = 1'b0;
        unique case (op)
            OpLh, OpLhu, OpSh: req_misaligned = addr[0];
            OpLw, OpSw:        req_misaligned = (addr[1:0] != 2'b00);
            default:           req_misaligned = 1'b0;
        endcase
        req_out_of_range = (addr < DM_BASE) || (addr > DmLast);
    end

    assign is_store_q = (op_q == OpSb) || (op_q == OpSh) || (op_q == OpSw);

    always_comb begin
        byte_shifted = dm_rdata >> {addr_q[1:0], 3'b000};
        load_byte    = byte_shifted[7:0];
        load_half    = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        unique case (op_q)
            OpLb:    load_val = {{24{load_byte[7]}}, load_byte};
            OpLbu:   load_val = {24'h0, load_byte};
            OpLh:    load_val = {{16{load_half[15]}}, load_half};
            OpLhu:   load_val = {16'h0, load_half};
            default: load_val = dm_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (req_misaligned || req_out_of_range) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!is_store_q) begin
                    rdata_d = load_val;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode registered state only, so an async reset drops them at once.
    always_comb begin
        dm_ena   = 1'b0;
        dm_rena  = 1'b0;
        dm_wena  = 1'b0;
        dm_wflag = 4'b0000;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        if (state_q == StAccess) begin
            dm_ena  = 1'b1;
            dm_addr = {addr_q[31:2], 2'b00};
            if (is_store_q) begin
                dm_wena = 1'b1;
                unique case (op_q)
                    OpSb: begin
                        dm_wflag = 4'b0001 << addr_q[1:0];
                        dm_wdata = {4{wdata_q[7:0]}};
                    end
                    OpSh: begin
                        dm_wflag = addr_q[1] ? 4'b1100 : 4'b0011;
                        dm_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        dm_wflag = 4'b1111;
                        dm_wdata = wdata_q;
                    end
                endcase
            end else begin
                dm_rena = 1'b1;
            end
        end
    end

    assign busy     = (state_q == StAccess);
    assign done     = done_q;
    assign addr_err = err_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master: a driver queues expected responses and strobes,
// a negedge monitor checks them against a behavioural data memory.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic [31:0] rdata;
    logic        dm_ena;
    logic        dm_rena;
    logic        dm_wena;
    logic [3:0]  dm_wflag;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    always #5 clk = ~clk;

    lsu_dmem_master dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .addr_err (addr_err),
        .rdata    (rdata),
        .dm_ena   (dm_ena),
        .dm_rena  (dm_rena),
        .dm_wena  (dm_wena),
        .dm_wflag (dm_wflag),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata)
    );

    // Behavioural 1 KiB data memory.
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [7:0]  widx;
    assign widx     = dm_addr[9:2];
    assign dm_rdata = dm_rena ? mem[widx] : 32'h0;

    always @(posedge clk) begin
        if (dm_ena && dm_wena) begin
            for (int l = 0; l < 4; l++) begin
                if (dm_wflag[l]) mem[widx][8*l +: 8] <= dm_wdata[8*l +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        rena;
        logic        wena;
        logic [3:0]  wflag;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    resp_t   resp_q[$];
    strobe_t strb_q[$];

    int tests = 0;
    int fails = 0;
    bit end_req = 1'b0;
    bit end_seen = 1'b0;

    always @(negedge clk) begin
        resp_t   r;
        strobe_t s;
        if (rst) begin
            tests++;
            if ({busy, done, addr_err, rdata, dm_ena, dm_rena, dm_wena, dm_wflag, dm_addr,
                 dm_wdata} != '0) begin
                fails++;
                $display("FAIL reset_outputs: busy=%b done=%b err=%b rdata=%h ena=%b wena=%b",
                         busy, done, addr_err, rdata, dm_ena, dm_wena);
            end
        end else begin
            if (done) begin
                tests++;
                if (resp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: done=1 with nothing outstanding");
                end else begin
                    r = resp_q.pop_front();
                    if (addr_err !== r.err) begin
                        fails++;
                        $display("FAIL addr_err: got %b want %b", addr_err, r.err);
                    end
                    tests++;
                    if (rdata !== r.rdata) begin
                        fails++;
                        $display("FAIL rdata: got %h want %h", rdata, r.rdata);
                    end
                    tests++;
                    if (cyc - r.cyc != r.lat) begin
                        fails++;
                        $display("FAIL latency: got %0d want %0d", cyc - r.cyc, r.lat);
                    end
                end
            end
            if (dm_ena) begin
                tests++;
                if (strb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: dm_ena=1 addr=%h", dm_addr);
                end else begin
                    s = strb_q.pop_front();
                    if (dm_rena !== s.rena || dm_wena !== s.wena || dm_wflag !== s.wflag ||
                        dm_addr !== s.addr || (s.wena && dm_wdata !== s.wdata)) begin
                        fails++;
                        $display("FAIL strobe: got r%b w%b f%b a=%h d=%h want r%b w%b f%b a=%h d=%h",
                                 dm_rena, dm_wena, dm_wflag, dm_addr, dm_wdata,
                                 s.rena, s.wena, s.wflag, s.addr, s.wdata);
                    end
                end
            end
            if ((dm_rena && dm_wena) ||
                (!busy && (dm_ena || dm_rena || dm_wena || dm_wflag != 4'b0))) begin
                tests++;
                fails++;
                $display("FAIL strobe_idle: busy=%b ena=%b rena=%b wena=%b flag=%b want idle-zero",
                         busy, dm_ena, dm_rena, dm_wena, dm_wflag);
            end
        end
        if (end_req && !end_seen) begin
            end_seen = 1'b1;
            tests++;
            if (resp_q.size() != 0 || strb_q.size() != 0) begin
                fails++;
                $display("FAIL leftover: %0d responses and %0d strobes still expected, want 0",
                         resp_q.size(), strb_q.size());
            end
        end
    end

    // Issue one request at a negedge; returns at the negedge of its done cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                         input logic e, input logic [31:0] r, input logic [3:0] fl,
                         input logic [31:0] da, input logic [31:0] dw);
        resp_t   rr;
        strobe_t ss;
        rr.err   = e;
        rr.rdata = r;
        rr.lat   = e ? 1 : 2;
        rr.cyc   = cyc;
        resp_q.push_back(rr);
        if (!e) begin
            ss.rena  = (o < 3'd5);
            ss.wena  = (o >= 3'd5);
            ss.wflag = fl;
            ss.addr  = da;
            ss.wdata = dw;
            strb_q.push_back(ss);
        end
        req   = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; op = 3'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        issue(3'b111, 32'h10010004, 32'hDEADBEEF, 1'b0, 32'h00000000, 4'b1111, 32'h10010004, 32'hDEADBEEF);
        issue(3'b100, 32'h10010004, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000, 32'h10010004, 32'h0);
        issue(3'b101, 32'h10010006, 32'h000000A5, 1'b0, 32'hDEADBEEF, 4'b0100, 32'h10010004, 32'hA5A5A5A5);
        issue(3'b000, 32'h10010006, 32'h0,        1'b0, 32'hFFFFFFA5, 4'b0000, 32'h10010004, 32'h0);
        issue(3'b001, 32'h10010006, 32'h0,        1'b0, 32'h000000A5, 4'b0000, 32'h10010004, 32'h0);
        issue(3'b100, 32'h10010004, 32'h0,        1'b0, 32'hDEA5BEEF, 4'b0000, 32'h10010004, 32'h0);
        issue(3'b110, 32'h10010002, 32'h00008001, 1'b0, 32'hDEA5BEEF, 4'b1100, 32'h10010000, 32'h80018001);
        issue(3'b010, 32'h10010002, 32'h0,        1'b0, 32'hFFFF8001, 4'b0000, 32'h10010000, 32'h0);
        issue(3'b011, 32'h10010002, 32'h0,        1'b0, 32'h00008001, 4'b0000, 32'h10010000, 32'h0);
        issue(3'b000, 32'h10010003, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000, 32'h10010000, 32'h0);
        issue(3'b010, 32'h10010004, 32'h0,        1'b0, 32'hFFFFBEEF, 4'b0000, 32'h10010004, 32'h0);
        // Misaligned and out-of-range: error after one cycle, rdata held.
        issue(3'b100, 32'h10010002, 32'h0,        1'b1, 32'hFFFFBEEF, 4'b0000, 32'h0, 32'h0);
        issue(3'b110, 32'h10010001, 32'h1234,     1'b1, 32'hFFFFBEEF, 4'b0000, 32'h0, 32'h0);
        issue(3'b100, 32'h1000FFFC, 32'h0,        1'b1, 32'hFFFFBEEF, 4'b0000, 32'h0, 32'h0);
        issue(3'b100, 32'h10010400, 32'h0,        1'b1, 32'hFFFFBEEF, 4'b0000, 32'h0, 32'h0);
        issue(3'b100, 32'h100103FC, 32'h0,        1'b0, 32'h00000000, 4'b0000, 32'h100103FC, 32'h0);
        issue(3'b111, 32'h10010008, 32'h12345678, 1'b0, 32'h00000000, 4'b1111, 32'h10010008, 32'h12345678);
        issue(3'b100, 32'h10010008, 32'h0,        1'b0, 32'h12345678, 4'b0000, 32'h10010008, 32'h0);
        // Reset in the middle of an ACCESS cycle: nothing is queued, so any done is flagged.
        req = 1'b1; op = 3'b100; addr = 32'h10010008;
        @(posedge clk);
        #1 req = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(3'b100, 32'h10010008, 32'h0,        1'b0, 32'h12345678, 4'b0000, 32'h10010008, 32'h0);
        end_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
